// File: rtl/btn_scan_pkg.sv
// Shared types and helpers for the button-matrix scanner.
package btn_scan_pkg;

  function automatic int get_width(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

  function automatic int evt_width(input int nkeys);
    return get_width(nkeys) + 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through sync FIFO for key events.
module evt_fifo
  import btn_scan_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = get_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // a full FIFO still takes a push when the head leaves the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr_en);
      rd_ptr <= rd_ptr + (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/btn_matrix_scan.sv
// Key-matrix scanner: column drive, per-key debounce, event FIFO.
module btn_matrix_scan
  import btn_scan_pkg::*;
#(
  parameter int CLK_FREQ   = 100,
  parameter int SCAN_US    = 20000,
  parameter int COLS       = 5,
  parameter int ROWS       = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int NKEYS     = COLS * ROWS,
  localparam int KEY_BITS  = get_width(NKEYS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [COLS-1:0]     btn_x,
  input  logic [ROWS-1:0]     btn_y,
  output logic [NKEYS-1:0]    key_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_BITS-1:0] evt_code,
  output logic                evt_press,
  output logic                overflow
);

  localparam int CNT_BITS   = get_width(DEBOUNCE + 1);
  localparam int COUNT_SCAN = CLK_FREQ * SCAN_US;
  localparam int TICK_BITS  = get_width(COUNT_SCAN);
  localparam int COL_BITS   = get_width(COLS);
  localparam int ROW_BITS   = get_width(ROWS);
  localparam int EVT_W      = KEY_BITS + 1;

  state_t               state_q;
  state_t               state_d;
  logic [TICK_BITS-1:0] tick_cnt;
  logic                 tick;
  logic [COL_BITS-1:0]  col_q;
  logic [COL_BITS-1:0]  cur_col;
  logic [ROWS-1:0]      samp;
  logic [ROW_BITS-1:0]  row_idx;
  logic [CNT_BITS-1:0]  cnt [NKEYS];
  logic [KEY_BITS-1:0]  key;
  logic                 s;
  logic                 walking;
  logic                 differ;
  logic                 hit;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [EVT_W-1:0]     dout;
  logic                 last_row;

  assign tick = (tick_cnt == TICK_BITS'(COUNT_SCAN - 1));

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_BITS'(1);
  end

  assign btn_x = ~(COLS'(1) << col_q);

  assign key      = KEY_BITS'(int'(cur_col) * ROWS + int'(row_idx));
  assign s        = samp[row_idx];
  assign walking  = (state_q == WALK);
  assign differ   = (s != key_state[key]);
  assign hit      = (cnt[key] == CNT_BITS'(DEBOUNCE - 1));
  assign push     = walking && differ && hit;
  assign last_row = (row_idx == ROW_BITS'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (tick)     state_d = WALK;
      (state_q == WALK): if (last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // sampling the old column lets each new column settle a full interval
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      cur_col   <= '0;
      samp      <= '0;
      row_idx   <= '0;
      key_state <= '0;
      cnt       <= '{default: '0};
      overflow  <= 1'b0;
    end else begin
      if (!walking && tick) begin
        samp    <= ~btn_y;
        cur_col <= col_q;
        col_q   <= (col_q == COL_BITS'(COLS - 1)) ?
                   '0 : col_q + COL_BITS'(1);
        row_idx <= '0;
      end
      if (walking) begin
        row_idx <= row_idx + ROW_BITS'(1);
        if (!differ) begin
          cnt[key] <= '0;
        end else if (hit) begin
          key_state[key] <= s;
          cnt[key]       <= '0;
        end else begin
          cnt[key] <= cnt[key] + CNT_BITS'(1);
        end
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign evt_code  = evt_valid ? dout[EVT_W-1:1] : '0;
  assign evt_press = evt_valid & dout[0];

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({key, s}),
    .pop   (pop),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_btn_matrix_scan.sv
// Bench for btn_matrix_scan: matrix emulation, event-level model,
// per-cycle compare and directed literal checks.
module tb_btn_matrix_scan;

  localparam int COLS  = 5;
  localparam int ROWS  = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int C     = 10;
  localparam int NK    = COLS * ROWS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] btn_x;
  logic [ROWS-1:0] btn_y;
  logic [NK-1:0]   key_state;
  logic            evt_valid;
  logic            evt_ready = 1'b1;
  logic [4:0]      evt_code;
  logic            evt_press;
  logic            overflow;

  logic [ROWS-1:0] phys [COLS];

  int n_cmp = 0;
  int n_bad = 0;

  int            m_n;
  logic [NK-1:0] m_st;
  int            m_cnt [NK];
  logic [5:0]    m_q [$];
  logic          m_ovf;
  int            m_scol;
  logic [ROWS-1:0] m_samp;
  logic [5:0]    log_q [$];

  always #5 clk = ~clk;

  btn_matrix_scan #(
    .CLK_FREQ   (1),
    .SCAN_US    (10),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .DEBOUNCE   (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_x     (btn_x),
    .btn_y     (btn_y),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .overflow  (overflow)
  );

  // physical matrix: a closed key pulls its row low when its column is driven
  always_comb begin
    btn_y = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (phys[c][r] && !btn_x[c]) btn_y[r] = 1'b0;
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference: time-indexed scan schedule, ideal debounce, ideal bounded queue
  initial begin
    int ph;
    int kk;
    logic sv;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_n = 0;
        m_st = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_q.delete();
        m_ovf = 1'b0;
        m_scol = 0;
        m_samp = '0;
      end else begin
        ph = m_n % C;
        if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
        if (m_n >= C && ph < ROWS) begin
          kk = m_scol * ROWS + ph;
          sv = m_samp[ph];
          if (sv == m_st[kk]) m_cnt[kk] = 0;
          else if (m_cnt[kk] + 1 == DEB) begin
            m_st[kk] = sv;
            m_cnt[kk] = 0;
            if (m_q.size() < DEPTH) m_q.push_back({kk[4:0], sv});
            else m_ovf = 1'b1;
          end else m_cnt[kk]++;
        end
        if (ph == C - 1) begin
          m_scol = (m_n / C) % COLS;
          m_samp = phys[m_scol];
        end
        m_n++;
      end
    end
  end

  initial begin
    logic [4:0] one5;
    logic [4:0] ex;
    logic [5:0] hd;
    one5 = 5'b00001;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ex = ~(one5 << ((m_n / C) % COLS));
      hd = (m_q.size() > 0) ? m_q[0] : 6'h00;
      check("btn_x", 32'(btn_x), 32'(ex));
      check("key_state", 32'(key_state), 32'(m_st));
      check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      check("evt_code", 32'(evt_code), 32'(hd[5:1]));
      check("evt_press", 32'(evt_press), 32'(hd[0]));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (evt_valid && evt_ready) log_q.push_back({evt_code, evt_press});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync50(input int target);
    for (int i = 0; i < 100 && (m_n % 50) != target; i++) step(1);
    if ((m_n % 50) != target) begin
      n_bad++;
      $display("FAIL sync: phase %0d expected %0d", m_n % 50, target);
    end
  endtask

  task automatic clear_all();
    foreach (phys[c]) phys[c] = '0;
  endtask

  initial begin
    logic [5:0] e;
    clear_all();
    rst = 1'b1;
    evt_ready = 1'b1;
    step(2);
    rst = 1'b0;

    // reset values and column walk
    check("rst_btn_x", 32'(btn_x), 32'h1e);
    check("rst_key_state", 32'(key_state), 32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    step(9);
    check("walk0", 32'(btn_x), 32'h1e);
    step(1);
    check("walk1", 32'(btn_x), 32'h1d);
    step(10);
    check("walk2", 32'(btn_x), 32'h1b);
    step(10);
    check("walk3", 32'(btn_x), 32'h17);
    step(10);
    check("walk4", 32'(btn_x), 32'h0f);
    step(10);
    check("walk5", 32'(btn_x), 32'h1e);

    // single key press and release
    log_q.delete();
    phys[2][1] = 1'b1;
    step(160);
    check("k9_press_state", 32'(key_state), 32'h200);
    check("k9_press_n", 32'(log_q.size()), 32'd1);
    e = (log_q.size() > 0) ? log_q[0] : 6'h3f;
    check("k9_press_evt", 32'(e), 32'h13);
    log_q.delete();
    phys[2][1] = 1'b0;
    step(160);
    check("k9_rel_state", 32'(key_state), 32'h0);
    e = (log_q.size() > 0) ? log_q[0] : 6'h3f;
    check("k9_rel_evt", 32'(e), 32'h12);

    // two-sample glitch, then a real three-sample hold
    log_q.delete();
    sync50(30);
    phys[2][1] = 1'b1;
    step(100);
    phys[2][1] = 1'b0;
    step(200);
    check("glitch_state", 32'(key_state), 32'h0);
    check("glitch_evts", 32'(log_q.size()), 32'd0);
    sync50(30);
    phys[2][1] = 1'b1;
    step(105);
    check("hold2_state", 32'(key_state), 32'h0);
    step(50);
    check("hold3_state", 32'(key_state), 32'h200);
    phys[2][1] = 1'b0;
    step(200);
    log_q.delete();

    // whole column 0 at once
    phys[0] = 4'hf;
    step(200);
    check("col0_state", 32'(key_state), 32'hf);
    check("col0_n", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = (i < log_q.size()) ? log_q[i] : 6'h3f;
      check("col0_evt", 32'(e), 32'(2 * i + 1));
    end
    phys[0] = 4'h0;
    step(200);
    log_q.delete();

    // overflow with a stalled consumer
    evt_ready = 1'b0;
    phys[1][0] = 1'b1;
    phys[2][0] = 1'b1;
    phys[3][0] = 1'b1;
    phys[4][0] = 1'b1;
    phys[4][1] = 1'b1;
    step(200);
    check("ovf_state", 32'(key_state), 32'h31110);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_valid", 32'(evt_valid), 32'h1);
    evt_ready = 1'b1;
    step(10);
    check("ovf_drain_n", 32'(log_q.size()), 32'd4);
    check("ovf_drain_valid", 32'(evt_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    clear_all();
    step(200);
    log_q.delete();

    // reset in the middle of a walk with events queued
    evt_ready = 1'b0;
    phys[0] = 4'hf;
    for (int i = 0; i < 300 && m_q.size() < 2; i++) step(1);
    if (m_q.size() < 2) begin
      n_bad++;
      $display("FAIL midwalk: queue never filled");
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    phys[0] = 4'h0;
    check("mid_btn_x", 32'(btn_x), 32'h1e);
    check("mid_key_state", 32'(key_state), 32'h0);
    check("mid_valid", 32'(evt_valid), 32'h0);
    check("mid_overflow", 32'(overflow), 32'h0);
    step(5);
    check("mid_stale", 32'(evt_valid), 32'h0);

    // random key activity and consumer stalls
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(24) == 0) begin
        int c;
        int r;
        c = $urandom_range(COLS - 1);
        r = $urandom_range(ROWS - 1);
        phys[c][r] = ~phys[c][r];
      end
      evt_ready = ($urandom_range(3) != 0);
      step(1);
    end
    evt_ready = 1'b1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
